iter_divider: RTL and testbench

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/iter_divider_pkg.sv | 14 +
 rtl/iter_divider_rca_16b.sv | 27 ++
 rtl/iter_divider.sv | 182 ++++++++++++++++++
 tb/tb_iter_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding
// and the default operand width.
package iter_divider_pkg;

    localparam int DEFAULT_N = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/iter_divider_rca_16b.sv
// Ripple-carry adder used for the divider's trial subtraction.
// The width defaults to 16 bits and follows the divider width when overridden.
module rca_16b #(
    parameter int W = 16
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         C_in,
    output logic [W-1:0] S,
    output logic         C_out
);

    logic [W:0] carry;

    // Bit-serial carry chain, LSB first.
    always_comb begin
        carry    = '0;
        S        = '0;
        carry[0] = C_in;
        for (int i = 0; i < W; i++) begin
            S[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        C_out = carry[W];
    end

endmodule

// File: rtl/iter_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// Signed operands are divided as magnitudes, and the signs are applied in a
// single fix-up cycle. Results truncate toward zero, and the remainder takes
// the sign of the dividend.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         sign,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Quo,
    output logic [N-1:0] Rem,
    output logic         DivZero,
    output logic         Ofl
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [N-1:0]     ONE       = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]     MOST_NEG  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]     ALL_ONES  = {N{1'b1}};

    state_t         state;
    state_t         state_nx;
    logic [CNT_W-1:0] cnt;

    // The working registers carry no reset; only control and the visible results do.
    // dvd shifts the dividend out at the top while quotient bits enter at the bottom.
    logic [N-1:0] dvd;
    logic [N-1:0] part_rem;
    logic [N-1:0] dvs;
    logic         quo_neg;
    logic         rem_neg;
    logic         ofl_pend;

    logic [N-1:0] quo_r;
    logic [N-1:0] rem_r;
    logic         divzero_r;
    logic         ofl_r;

    logic         accept;
    logic         div_zero_in;
    logic         a_neg;
    logic         b_neg;
    logic [N-1:0] a_mag;
    logic [N-1:0] b_mag;

    logic [N-1:0] trial;
    logic [N-1:0] dvs_inv;
    logic [N-1:0] diff;
    logic         no_borrow;

    // Decode the incoming request and form the operand magnitudes.
    always_comb begin
        accept      = (state == IDLE) && Start;
        div_zero_in = (B == '0);
        a_neg       = sign & A[N-1];
        b_neg       = sign & B[N-1];
        a_mag       = a_neg ? (~A + ONE) : A;
        b_mag       = b_neg ? (~B + ONE) : B;
    end

    // Shift the next dividend bit into the partial remainder.
    // The remainder entering step i is below 2^i, so its MSB is always 0 here
    // and dropping it loses nothing.
    always_comb begin
        trial   = {part_rem[N-2:0], dvd[N-1]};
        dvs_inv = ~dvs;
    end

    rca_16b #(
        .W(N)
    ) u_sub (
        .A    (trial),
        .B    (dvs_inv),
        .C_in (1'b1),
        .S    (diff),
        .C_out(no_borrow)
    );

    // Update the state register. Reset aborts any divide in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Select the next state and decode the status outputs.
    always_comb begin
        state_nx = state;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nx = div_zero_in ? DONE : CALC;
                end
            end
            CALC: begin
                Busy = 1'b1;
                if (cnt == LAST_STEP) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                Busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                Done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Count the quotient steps. The counter wraps to 0 after the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CALC) begin
            cnt <= (cnt == LAST_STEP) ? '0 : cnt + CNT_ONE;
        end
    end

    // Capture the operands, then run one restoring step per CALC cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd      <= a_mag;
            dvs      <= b_mag;
            part_rem <= '0;
            quo_neg  <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            ofl_pend <= sign && (A == MOST_NEG) && (B == ALL_ONES);
        end else if (state == CALC) begin
            if (no_borrow) begin
                part_rem <= diff;
                dvd      <= {dvd[N-2:0], 1'b1};
            end else begin
                part_rem <= trial;
                dvd      <= {dvd[N-2:0], 1'b0};
            end
        end
    end

    // Maintain the visible results. They hold from DONE until the next accepted Start.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_r     <= '0;
            rem_r     <= '0;
            divzero_r <= 1'b0;
            ofl_r     <= 1'b0;
        end else if (accept) begin
            divzero_r <= div_zero_in;
            ofl_r     <= 1'b0;
            if (div_zero_in) begin
                quo_r <= ALL_ONES;
                rem_r <= A;
            end
        end else if (state == FIX) begin
            quo_r <= quo_neg ? (~dvd + ONE) : dvd;
            rem_r <= rem_neg ? (~part_rem + ONE) : part_rem;
            ofl_r <= ofl_pend;
        end
    end

    assign Quo     = quo_r;
    assign Rem     = rem_r;
    assign DivZero = divzero_r;
    assign Ofl     = ofl_r;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider (N=16): hand-computed vectors, latency,
// signed and unsigned boundary cases, ignored Start, and reset abort.
module tb_iter_divider;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         Start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         sign;
    logic         Busy;
    logic         Done;
    logic [N-1:0] Quo;
    logic [N-1:0] Rem;
    logic         DivZero;
    logic         Ofl;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int d0;
    int n;

    iter_divider #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .sign   (sign),
        .Busy   (Busy),
        .Done   (Done),
        .Quo    (Quo),
        .Rem    (Rem),
        .DivZero(DivZero),
        .Ofl    (Ofl)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The latency is the number of edges from the Start edge to the first edge that samples Done=1.
    task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic s, input int exp_lat, input logic [N-1:0] eq,
                           input logic [N-1:0] er, input logic ez, input logic eo);
        int cyc;
        @(negedge clk);
        A = a; B = b; sign = s; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        if (b != '0) begin
            check({tag, ".busy"}, 32'(Busy), 32'(1));
            check({tag, ".flags_clr"}, 32'({DivZero, Ofl}), 32'(0));
        end
        cyc = 0;
        while (Done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, ".lat"}, 32'(cyc + 1), 32'(exp_lat));
        check({tag, ".quo"}, 32'(Quo), 32'(eq));
        check({tag, ".rem"}, 32'(Rem), 32'(er));
        check({tag, ".divzero"}, 32'(DivZero), 32'(ez));
        check({tag, ".ofl"}, 32'(Ofl), 32'(eo));
        check({tag, ".busy_done"}, 32'(Busy), 32'(0));
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, 32'(Done), 32'(0));
        check({tag, ".hold"}, 32'({Quo, Rem}), {eq, er});
    endtask

    initial begin
        rst = 1'b1; Start = 1'b0; A = '0; B = '0; sign = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy_done", 32'({Busy, Done}), 32'(0));
        check("rst.quo_rem", {Quo, Rem}, 32'(0));
        check("rst.flags", 32'({DivZero, Ofl}), 32'(0));

        // The first Start coincides with the first edge that sees rst=0.
        @(negedge clk);
        rst = 1'b0;
        A = 16'd100; B = 16'd7; sign = 1'b0; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        check("first.busy", 32'(Busy), 32'(1));
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("first.lat", 32'(n + 1), 32'(N + 2));
        check("first.quo_rem", {Quo, Rem}, {16'd14, 16'd2});
        @(posedge clk);
        #1;

        run_div("u100_7",   16'd100,  16'd7,    1'b0, N + 2, 16'd14,   16'd2,    1'b0, 1'b0);
        run_div("s-7_2",    16'hFFF9, 16'd2,    1'b1, N + 2, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
        run_div("s7_-2",    16'd7,    16'hFFFE, 1'b1, N + 2, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
        run_div("divzero",  16'h1234, 16'h0000, 1'b0, 1,     16'hFFFF, 16'h1234, 1'b1, 1'b0);
        run_div("s_ofl",    16'h8000, 16'hFFFF, 1'b1, N + 2, 16'h8000, 16'h0000, 1'b0, 1'b1);
        run_div("u_8000",   16'h8000, 16'hFFFF, 1'b0, N + 2, 16'h0000, 16'h8000, 1'b0, 1'b0);
        run_div("s-100_-7", 16'hFF9C, 16'hFFF9, 1'b1, N + 2, 16'h000E, 16'hFFFE, 1'b0, 1'b0);
        run_div("uFFFF_1",  16'hFFFF, 16'h0001, 1'b0, N + 2, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        run_div("u5_9",     16'd5,    16'd9,    1'b0, N + 2, 16'h0000, 16'h0005, 1'b0, 1'b0);
        run_div("s-5_3",    16'hFFFB, 16'd3,    1'b1, N + 2, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);

        // A Start pulse during CALC is ignored and yields exactly one Done.
        d0 = done_cnt;
        @(negedge clk);
        A = 16'd100; B = 16'd7; sign = 1'b0; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        A = 16'd1; B = 16'd1; sign = 1'b1; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("ign.quo_rem", {Quo, Rem}, {16'd14, 16'd2});
        // A Start held only during the DONE cycle is not accepted.
        A = 16'd3; B = 16'd1; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        check("done_start.busy", 32'(Busy), 32'(0));
        @(posedge clk);
        #1;
        check("done_start.idle", 32'({Busy, Done}), 32'(0));
        check("done_start.hold", {Quo, Rem}, {16'd14, 16'd2});
        repeat (20) @(posedge clk);
        #1;
        check("ign.one_done", 32'(done_cnt - d0), 32'(1));

        // Reset in the middle of CALC aborts the divide without a Done pulse.
        @(negedge clk);
        A = 16'd200; B = 16'd9; sign = 1'b0; Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (5) @(posedge clk);
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.busy_done", 32'({Busy, Done}), 32'(0));
        check("abort.quo_rem", {Quo, Rem}, 32'(0));
        check("abort.flags", 32'({DivZero, Ofl}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("abort.no_done", 32'(done_cnt - d0), 32'(0));
        run_div("after_abort", 16'd200, 16'd9, 1'b0, N + 2, 16'd22, 16'd2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
